dmi_dtm_core: RTL and testbench
===============================

DMI_DTM_CORE -- requirements
Module: dmi_dtm_core

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 7, meaning DMI address width (legal 7..16).
REQ-002 The block SHALL have parameter IdleHint, default 1, meaning the 3-bit value reported in dtmcs.idle.
REQ-003 The block SHALL have parameter TimeoutCycles, default 0, meaning tck cycles allowed in WaitResp before abort (0 = disabled).
REQ-004 tck_i  in  1  JTAG clock; all state on rising edge.
REQ-005 trst_ni  in  1  reset, asynchronous, active-low.
REQ-006 test_logic_reset_i, capture_dr_i, shift_dr_i, update_dr_i  in  1 each  TAP state strobes.
REQ-007 dmi_access_i, dtmcs_select_i  in  1 each  IR selects DMI or DTMCS data register.
REQ-008 tdi_i  in  1  serial data in; tdo_o  out  1  serial data out.
REQ-009 req_addr_o  out  AddrWidth, req_data_o  out  32, req_op_o  out  2 (1 read, 2 write), req_valid_o  out  1, req_ready_i  in  1: request channel.
REQ-010 resp_data_i  in  32, resp_resp_i  in  2, resp_valid_i  in  1, resp_ready_o  out  1: response channel.

Function
REQ-011 DMI DR SHALL be AddrWidth+34 bits: [AddrWidth+33:34] address, [33:2] data, [1:0] op; DTMCS DR SHALL be 32 bits.
REQ-012 On shift_dr_i, the selected DR SHALL shift right one bit with tdi_i into the MSB; tdo_o SHALL equal bit 0 of the selected DR (DMI if dmi_access_i, else DTMCS, else 0).
REQ-013 DTMCS capture SHALL load {14'b0, 2'b00, 1'b0, IdleHint[2:0], error_q[1:0], AddrWidth[5:0], 4'd1}.
REQ-014 FSM states SHALL be Idle, Req, WaitResp; address, data and op are held in registers driving req_*_o.
REQ-015 Idle: update_dr_i with dmi_access_i and error_q==0 SHALL latch address/data/op; op 1 or 2 -> Req; op 0 or 3 -> stay Idle (no request).
REQ-016 Req: req_valid_o SHALL be 1 and payload stable until req_ready_i; on req_valid_o&&req_ready_i -> WaitResp next cycle.
REQ-017 WaitResp: resp_ready_o SHALL be 1 (0 in all other states); on resp_valid_i -> Idle, data register loads resp_data_i only for reads.
REQ-018 resp_resp_i==2 or 3 on an accepted response SHALL set error_q to 2 (failed) unless error_q is already 3.
REQ-019 update_dr_i or capture_dr_i with dmi_access_i while state!=Idle SHALL set error_q to 3 (busy), sticky; the triggering update SHALL be ignored.
REQ-020 DMI capture SHALL load {address, data, e} where e=3 if busy is detected in that same cycle, else error_q.
REQ-021 With TimeoutCycles>0, a counter SHALL count tck cycles in WaitResp from 0; on reaching TimeoutCycles -> Idle, error_q=2, counter cleared; response arriving in the same cycle wins.
REQ-022 DTMCS update with bit 16 (dmireset) set SHALL clear error_q to 0.
REQ-023 DTMCS update with bit 17 (dmihardreset) set SHALL force Idle, clear error_q and counter, and drop req_valid_o next cycle; it wins over every simultaneous event.
REQ-024 req_valid_o SHALL only drop without handshake via dmihardreset, test_logic_reset_i or trst_ni.
REQ-025 Operation latency: update_dr_i -> req_valid_o high SHALL be exactly 1 tck cycle.

Reset
REQ-026 trst_ni low SHALL clear both DRs, address, data, op, counter, error_q to 0 and state to Idle; req_valid_o=0, resp_ready_o=0, tdo_o=0.
REQ-027 test_logic_reset_i high SHALL have the same effect as trst_ni synchronously, including mid-transaction abort.

Structure
REQ-028 Shared package SHALL hold dtm_op_e, dmi_error_e (0 none, 1 reserved, 2 failed, 3 busy), the DTMCS field struct and DTM version constant.
REQ-029 The timeout counter SHALL be one sub-module dtm_timeout_cnt (width $clog2(TimeoutCycles+1), enable, clear, expired), omitted by generate when TimeoutCycles==0.

Verification
REQ-030 Write addr 0x10 data 0xDEADBEEF op 2, req_ready_i after 3 cycles, resp 0 -> one req handshake with those values, next DMI capture op field 0.
REQ-031 Read addr 0x04, resp_data_i 0x12345678 -> next DMI capture data 0x12345678, op field 0.
REQ-032 Second update during WaitResp -> error_q=3, no second request; DTMCS update 0x00010000 -> error_q=0.
REQ-033 Response resp_resp_i=2 -> DTMCS capture bits[11:10]=2; subsequent DMI updates ignored until dmireset.
REQ-034 TimeoutCycles=8, no response -> Idle after 8 cycles in WaitResp, error_q=2; dmihardreset in Req -> req_valid_o low next cycle.
REQ-035 Defaults, DTMCS capture -> 0x00001071; AddrWidth=12 -> 0x000010C1 and DMI DR length 46.

Source files
------------

// File: rtl/dmi_dtm_core_pkg.sv
// Shared types and constants for the JTAG debug transport module.
package dmi_dtm_core_pkg;

   localparam logic [3:0] DTM_VERSION = 4'd1;

   typedef enum logic [1:0] {
      DTM_NOP   = 2'd0,
      DTM_READ  = 2'd1,
      DTM_WRITE = 2'd2,
      DTM_RSVD  = 2'd3
   } dtm_op_e;

   typedef enum logic [1:0] {
      DMI_ERR_NONE   = 2'd0,
      DMI_ERR_RSVD   = 2'd1,
      DMI_ERR_FAILED = 2'd2,
      DMI_ERR_BUSY   = 2'd3
   } dmi_error_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } dtm_state_e;

   typedef struct packed {
      logic [13:0] zero_hi;
      logic        dmihardreset;
      logic        dmireset;
      logic        zero_lo;
      logic [2:0]  idle;
      logic [1:0]  dmistat;
      logic [5:0]  abits;
      logic [3:0]  version;
   } dtmcs_t;

endpackage

// File: rtl/dtm_timeout_cnt.sv
// Up-counter of tck cycles spent waiting for a DMI response, with a
// terminal-count compare that flags the last allowed cycle.
module dtm_timeout_cnt #(
   parameter int unsigned Limit = 8,
   parameter int unsigned Width = $clog2(Limit + 1)
) (
   input  logic tck,
   input  logic trst_n,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam logic [Width-1:0] Last = Width'(Limit - 1);

   logic [Width-1:0] cnt;

   // Expiry fires in the cycle whose closing edge would bring the count to Limit.
   assign expired = enable && (cnt == Last);

   // Count while enabled; restart whenever the wait ends or expires.
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         cnt <= '0;
      end else if (clear || expired) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dmi_dtm_core.sv
// JTAG debug transport core: DMI and DTMCS data registers plus the
// request/response sequencer toward the debug module interface.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; DMI updates may launch a read or write
// ST_REQ   | req_valid_o high, payload held until req_ready_i
// ST_WAIT  | resp_ready_o high, waiting for response (or timeout)
module dmi_dtm_core
   import dmi_dtm_core_pkg::*;
#(
   parameter int unsigned AddrWidth     = 7,
   parameter int unsigned IdleHint      = 1,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic                 tck_i,
   input  logic                 trst_ni,
   input  logic                 test_logic_reset_i,
   input  logic                 capture_dr_i,
   input  logic                 shift_dr_i,
   input  logic                 update_dr_i,
   input  logic                 dmi_access_i,
   input  logic                 dtmcs_select_i,
   input  logic                 tdi_i,
   output logic                 tdo_o,
   output logic [AddrWidth-1:0] req_addr_o,
   output logic [31:0]          req_data_o,
   output logic [1:0]           req_op_o,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   input  logic [31:0]          resp_data_i,
   input  logic [1:0]           resp_resp_i,
   input  logic                 resp_valid_i,
   output logic                 resp_ready_o
);

   localparam int unsigned DmiWidth = AddrWidth + 34;

   logic [DmiWidth-1:0]  dmi_dr;
   logic [31:0]          dtmcs_dr;
   dtm_state_e           state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [31:0]          data_q, data_d;
   dtm_op_e              op_q, op_d;
   dmi_error_e           error_q, error_d;

   logic      dmi_update, dmi_capture, dtmcs_update;
   logic      hard_reset, soft_reset, busy, timeout_hit;
   logic [1:0] cap_err;
   dtmcs_t    dtmcs_cap;

   assign dmi_update   = update_dr_i && dmi_access_i;
   assign dmi_capture  = capture_dr_i && dmi_access_i;
   assign dtmcs_update = update_dr_i && !dmi_access_i && dtmcs_select_i;
   assign hard_reset   = dtmcs_update && dtmcs_dr[17];
   assign soft_reset   = dtmcs_update && dtmcs_dr[16];
   assign busy         = (dmi_update || dmi_capture) && (state_q != ST_IDLE);

   // A capture that collides with an active transaction already reports busy.
   assign cap_err = busy ? 2'd3 : error_q;

   // DTMCS capture image built from the live sticky error and parameters.
   always_comb begin
      dtmcs_cap         = '0;
      dtmcs_cap.idle    = 3'(IdleHint);
      dtmcs_cap.dmistat = error_q;
      dtmcs_cap.abits   = 6'(AddrWidth);
      dtmcs_cap.version = DTM_VERSION;
   end

   // Capture and shift of whichever data register the IR selects.
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         dmi_dr   <= '0;
         dtmcs_dr <= '0;
      end else if (test_logic_reset_i) begin
         dmi_dr   <= '0;
         dtmcs_dr <= '0;
      end else if (dmi_access_i) begin
         if (capture_dr_i) begin
            dmi_dr <= {addr_q, data_q, cap_err};
         end else if (shift_dr_i) begin
            dmi_dr <= {tdi_i, dmi_dr[DmiWidth-1:1]};
         end
      end else if (dtmcs_select_i) begin
         if (capture_dr_i) begin
            dtmcs_dr <= dtmcs_cap;
         end else if (shift_dr_i) begin
            dtmcs_dr <= {tdi_i, dtmcs_dr[31:1]};
         end
      end
   end

   // Serial output follows bit 0 of the selected register.
   always_comb begin
      tdo_o = 1'b0;
      if (dmi_access_i) begin
         tdo_o = dmi_dr[0];
      end else if (dtmcs_select_i) begin
         tdo_o = dtmcs_dr[0];
      end
   end

   generate
      if (TimeoutCycles > 0) begin : g_timeout
         logic cnt_enable, cnt_clear;
         assign cnt_enable = (state_q == ST_WAIT);
         assign cnt_clear  = (state_q != ST_WAIT) || resp_valid_i ||
                             hard_reset || test_logic_reset_i;
         dtm_timeout_cnt #(
            .Limit (TimeoutCycles)
         ) u_timeout_cnt (
            .tck     (tck_i),
            .trst_n  (trst_ni),
            .enable  (cnt_enable),
            .clear   (cnt_clear),
            .expired (timeout_hit)
         );
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // Next-state and payload/error update; later assignments take priority.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      op_d    = op_q;
      error_d = error_q;
      case (state_q)
         ST_IDLE: begin
            if (dmi_update && (error_q == DMI_ERR_NONE)) begin
               addr_d = dmi_dr[DmiWidth-1:34];
               data_d = dmi_dr[33:2];
               op_d   = dtm_op_e'(dmi_dr[1:0]);
               if (op_d == DTM_READ || op_d == DTM_WRITE) begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (req_ready_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (resp_valid_i) begin
               state_d = ST_IDLE;
               if (op_q == DTM_READ) begin
                  data_d = resp_data_i;
               end
               if (resp_resp_i >= 2'd2 && error_q != DMI_ERR_BUSY) begin
                  error_d = DMI_ERR_FAILED;
               end
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
               if (error_q != DMI_ERR_BUSY) begin
                  error_d = DMI_ERR_FAILED;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (busy) begin
         error_d = DMI_ERR_BUSY;
      end
      if (soft_reset) begin
         error_d = DMI_ERR_NONE;
      end
      if (hard_reset) begin
         state_d = ST_IDLE;
         error_d = DMI_ERR_NONE;
      end
      if (test_logic_reset_i) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         data_d  = '0;
         op_d    = DTM_NOP;
         error_d = DMI_ERR_NONE;
      end
   end

   // Sequencer state and held request payload.
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         op_q    <= DTM_NOP;
         error_q <= DMI_ERR_NONE;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         op_q    <= op_d;
         error_q <= error_d;
      end
   end

   assign req_addr_o   = addr_q;
   assign req_data_o   = data_q;
   assign req_op_o     = op_q;
   assign req_valid_o  = (state_q == ST_REQ);
   assign resp_ready_o = (state_q == ST_WAIT);

endmodule

// File: tb/tb_dmi_dtm_core.sv
// Directed bench for dmi_dtm_core: a default instance (A) and an instance
// with AddrWidth=12, TimeoutCycles=8 (B) share all stimulus.
module tb_dmi_dtm_core;

   logic        tck = 1'b0;
   logic        trst_n, tlr, cap, shf, upd, dmi_acc, dtmcs_sel, tdi;
   logic        req_ready, resp_valid;
   logic [31:0] resp_data;
   logic [1:0]  resp_resp;

   logic        tdo_a, req_valid_a, resp_ready_a;
   logic [6:0]  req_addr_a;
   logic [31:0] req_data_a;
   logic [1:0]  req_op_a;

   logic        tdo_b, req_valid_b, resp_ready_b;
   logic [11:0] req_addr_b;
   logic [31:0] req_data_b;
   logic [1:0]  req_op_b;

   int total = 0;
   int bad   = 0;
   int hs_count = 0;
   logic [6:0]  hs_addr;
   logic [31:0] hs_data;
   logic [1:0]  hs_op;

   always #5 tck = ~tck;

   dmi_dtm_core u_dut_a (
      .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr),
      .capture_dr_i(cap), .shift_dr_i(shf), .update_dr_i(upd),
      .dmi_access_i(dmi_acc), .dtmcs_select_i(dtmcs_sel),
      .tdi_i(tdi), .tdo_o(tdo_a),
      .req_addr_o(req_addr_a), .req_data_o(req_data_a), .req_op_o(req_op_a),
      .req_valid_o(req_valid_a), .req_ready_i(req_ready),
      .resp_data_i(resp_data), .resp_resp_i(resp_resp),
      .resp_valid_i(resp_valid), .resp_ready_o(resp_ready_a)
   );

   dmi_dtm_core #(.AddrWidth(12), .TimeoutCycles(8)) u_dut_b (
      .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr),
      .capture_dr_i(cap), .shift_dr_i(shf), .update_dr_i(upd),
      .dmi_access_i(dmi_acc), .dtmcs_select_i(dtmcs_sel),
      .tdi_i(tdi), .tdo_o(tdo_b),
      .req_addr_o(req_addr_b), .req_data_o(req_data_b), .req_op_o(req_op_b),
      .req_valid_o(req_valid_b), .req_ready_i(req_ready),
      .resp_data_i(resp_data), .resp_resp_i(resp_resp),
      .resp_valid_i(resp_valid), .resp_ready_o(resp_ready_b)
   );

   // Handshake monitor for instance A, sampled mid-cycle.
   always @(negedge tck) begin
      if (req_valid_a && req_ready) begin
         hs_count = hs_count + 1;
         hs_addr  = req_addr_a;
         hs_data  = req_data_a;
         hs_op    = req_op_a;
      end
   end

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic shift_dmi(input logic [63:0] val, input int nbits);
      dmi_acc = 1'b1; dtmcs_sel = 1'b0;
      cap = 1'b1; tick(); cap = 1'b0;
      shf = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         tdi = val[i];
         tick();
      end
      shf = 1'b0; tdi = 1'b0;
      upd = 1'b1; tick(); upd = 1'b0;
   endtask

   task automatic capture_dmi(output logic [63:0] va, output logic [63:0] vb);
      va = '0; vb = '0;
      dmi_acc = 1'b1; dtmcs_sel = 1'b0;
      cap = 1'b1; tick(); cap = 1'b0;
      shf = 1'b1; tdi = 1'b0;
      for (int i = 0; i < 46; i++) begin
         if (i < 41) va[i] = tdo_a;
         vb[i] = tdo_b;
         tick();
      end
      shf = 1'b0;
   endtask

   task automatic capture_dtmcs(output logic [31:0] va, output logic [31:0] vb);
      dmi_acc = 1'b0; dtmcs_sel = 1'b1;
      cap = 1'b1; tick(); cap = 1'b0;
      shf = 1'b1; tdi = 1'b0;
      for (int i = 0; i < 32; i++) begin
         va[i] = tdo_a;
         vb[i] = tdo_b;
         tick();
      end
      shf = 1'b0; dtmcs_sel = 1'b0;
   endtask

   task automatic update_dtmcs(input logic [31:0] v);
      dmi_acc = 1'b0; dtmcs_sel = 1'b1;
      shf = 1'b1;
      for (int i = 0; i < 32; i++) begin
         tdi = v[i];
         tick();
      end
      shf = 1'b0; tdi = 1'b0;
      upd = 1'b1; tick(); upd = 1'b0;
      dtmcs_sel = 1'b0;
   endtask

   task automatic handshake();
      req_ready = 1'b1; tick(); req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic [1:0] r);
      resp_data = d; resp_resp = r; resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0; resp_resp = 2'd0;
   endtask

   task automatic test_reset();
      trst_n = 1'b0; tlr = 1'b0; cap = 1'b0; shf = 1'b0; upd = 1'b0;
      dmi_acc = 1'b1; dtmcs_sel = 1'b0; tdi = 1'b0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_resp = '0;
      tick(); tick();
      total++;
      if (req_valid_a !== 1'b0 || resp_ready_a !== 1'b0 || tdo_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%b ready=%b tdo=%b expected 0 0 0",
                  req_valid_a, resp_ready_a, tdo_a);
      end
      total++;
      if (req_addr_a !== 7'd0 || req_data_a !== 32'd0 || req_op_a !== 2'd0) begin
         bad++;
         $display("FAIL reset_payload: got %h %h %h expected 0 0 0",
                  req_addr_a, req_data_a, req_op_a);
      end
      #2 trst_n = 1'b1;
      tick();
   endtask

   task automatic test_dtmcs_default();
      logic [31:0] va, vb;
      capture_dtmcs(va, vb);
      total++;
      if (va !== 32'h0000_1071) begin
         bad++;
         $display("FAIL dtmcs_default_a: got %h expected 00001071", va);
      end
      total++;
      if (vb !== 32'h0000_10C1) begin
         bad++;
         $display("FAIL dtmcs_aw12_b: got %h expected 000010c1", vb);
      end
   endtask

   task automatic test_dr_length();
      dmi_acc = 1'b1;
      cap = 1'b1; tick(); cap = 1'b0;
      shf = 1'b1; tdi = 1'b1;
      for (int i = 1; i <= 46; i++) begin
         tick();
         if (i == 40 || i == 41) begin
            total++;
            if (tdo_a !== (i == 41)) begin
               bad++;
               $display("FAIL dmi_len_a: after %0d shifts got tdo=%b expected %b",
                        i, tdo_a, (i == 41));
            end
         end
         if (i == 45 || i == 46) begin
            total++;
            if (tdo_b !== (i == 46)) begin
               bad++;
               $display("FAIL dmi_len_b: after %0d shifts got tdo=%b expected %b",
                        i, tdo_b, (i == 46));
            end
         end
      end
      shf = 1'b0; tdi = 1'b0;
   endtask

   task automatic test_write();
      logic [63:0] va, vb;
      shift_dmi({23'd0, 7'h10, 32'hDEAD_BEEF, 2'd2}, 41);
      total++;
      if (req_valid_a !== 1'b1 || req_addr_a !== 7'h10 ||
          req_data_a !== 32'hDEAD_BEEF || req_op_a !== 2'd2) begin
         bad++;
         $display("FAIL write_req: got v=%b a=%h d=%h op=%0d expected 1 10 deadbeef 2",
                  req_valid_a, req_addr_a, req_data_a, req_op_a);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (req_valid_a !== 1'b1 || req_data_a !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_hold: cycle %0d got v=%b d=%h expected 1 deadbeef",
                     i, req_valid_a, req_data_a);
         end
      end
      handshake();
      total++;
      if (resp_ready_a !== 1'b1 || req_valid_a !== 1'b0) begin
         bad++;
         $display("FAIL write_wait: got resp_ready=%b req_valid=%b expected 1 0",
                  resp_ready_a, req_valid_a);
      end
      respond(32'h0, 2'd0);
      total++;
      if (hs_count !== 1 || hs_addr !== 7'h10 || hs_data !== 32'hDEAD_BEEF ||
          hs_op !== 2'd2 || resp_ready_a !== 1'b0) begin
         bad++;
         $display("FAIL write_hs: got n=%0d a=%h d=%h op=%0d rr=%b expected 1 10 deadbeef 2 0",
                  hs_count, hs_addr, hs_data, hs_op, resp_ready_a);
      end
      capture_dmi(va, vb);
      total++;
      if (va[40:0] !== {7'h10, 32'hDEAD_BEEF, 2'd0}) begin
         bad++;
         $display("FAIL write_capture: got %h expected %h",
                  va[40:0], {7'h10, 32'hDEAD_BEEF, 2'd0});
      end
   endtask

   task automatic test_read();
      logic [63:0] va, vb;
      shift_dmi({23'd0, 7'h04, 32'h0, 2'd1}, 41);
      total++;
      if (req_valid_a !== 1'b1 || req_addr_a !== 7'h04 || req_op_a !== 2'd1) begin
         bad++;
         $display("FAIL read_req: got v=%b a=%h op=%0d expected 1 04 1",
                  req_valid_a, req_addr_a, req_op_a);
      end
      handshake();
      respond(32'h1234_5678, 2'd0);
      capture_dmi(va, vb);
      total++;
      if (va[40:0] !== {7'h04, 32'h1234_5678, 2'd0} || hs_count !== 2) begin
         bad++;
         $display("FAIL read_capture: got %h n=%0d expected %h n=2",
                  va[40:0], hs_count, {7'h04, 32'h1234_5678, 2'd0});
      end
   endtask

   task automatic test_busy();
      logic [63:0] va, vb;
      logic [31:0] da, db;
      shift_dmi({23'd0, 7'h20, 32'h1, 2'd2}, 41);
      handshake();
      shift_dmi({23'd0, 7'h21, 32'h2, 2'd2}, 41);
      total++;
      if (resp_ready_a !== 1'b1 || req_valid_a !== 1'b0 || req_addr_a !== 7'h20) begin
         bad++;
         $display("FAIL busy_ignored: got rr=%b v=%b a=%h expected 1 0 20",
                  resp_ready_a, req_valid_a, req_addr_a);
      end
      respond(32'h0, 2'd0);
      tick(); tick();
      total++;
      if (hs_count !== 3) begin
         bad++;
         $display("FAIL busy_no_second_req: got %0d handshakes expected 3", hs_count);
      end
      capture_dmi(va, vb);
      total++;
      if (va[1:0] !== 2'd3) begin
         bad++;
         $display("FAIL busy_dmi_op: got %0d expected 3", va[1:0]);
      end
      capture_dtmcs(da, db);
      total++;
      if (da !== 32'h0000_1C71) begin
         bad++;
         $display("FAIL busy_dtmcs: got %h expected 00001c71", da);
      end
      update_dtmcs(32'h0001_0000);
      capture_dtmcs(da, db);
      total++;
      if (da !== 32'h0000_1071) begin
         bad++;
         $display("FAIL dmireset_clear: got %h expected 00001071", da);
      end
   endtask

   task automatic test_failed();
      logic [31:0] da, db;
      shift_dmi({23'd0, 7'h05, 32'h0, 2'd1}, 41);
      handshake();
      respond(32'hCAFE_0000, 2'd2);
      capture_dtmcs(da, db);
      total++;
      if (da[11:10] !== 2'd2) begin
         bad++;
         $display("FAIL failed_dmistat: got %0d expected 2", da[11:10]);
      end
      shift_dmi({23'd0, 7'h30, 32'h7, 2'd2}, 41);
      total++;
      if (req_valid_a !== 1'b0 || hs_count !== 4) begin
         bad++;
         $display("FAIL failed_blocks_update: got v=%b n=%0d expected 0 4",
                  req_valid_a, hs_count);
      end
      update_dtmcs(32'h0001_0000);
      shift_dmi({23'd0, 7'h30, 32'h7, 2'd2}, 41);
      total++;
      if (req_valid_a !== 1'b1 || req_addr_a !== 7'h30) begin
         bad++;
         $display("FAIL after_dmireset_req: got v=%b a=%h expected 1 30",
                  req_valid_a, req_addr_a);
      end
      handshake();
      respond(32'h0, 2'd0);
   endtask

   task automatic test_tlr_abort();
      logic [31:0] da, db;
      tlr = 1'b1; tick(); tlr = 1'b0;
      shift_dmi({23'd0, 7'h11, 32'hA5, 2'd2}, 41);
      total++;
      if (req_valid_a !== 1'b1) begin
         bad++;
         $display("FAIL tlr_pre_req: got v=%b expected 1", req_valid_a);
      end
      tlr = 1'b1; tick(); tlr = 1'b0;
      total++;
      if (req_valid_a !== 1'b0 || req_addr_a !== 7'd0 || req_data_a !== 32'd0 ||
          req_op_a !== 2'd0) begin
         bad++;
         $display("FAIL tlr_abort: got v=%b a=%h d=%h op=%0d expected 0 0 0 0",
                  req_valid_a, req_addr_a, req_data_a, req_op_a);
      end
      capture_dtmcs(da, db);
      total++;
      if (da !== 32'h0000_1071) begin
         bad++;
         $display("FAIL tlr_dtmcs: got %h expected 00001071", da);
      end
   endtask

   task automatic test_timeout_hardreset();
      logic [31:0] da, db;
      int n;
      tlr = 1'b1; tick(); tlr = 1'b0;
      shift_dmi({18'd0, 12'h0AB, 32'h55, 2'd2}, 46);
      total++;
      if (req_valid_b !== 1'b1 || req_addr_b !== 12'h0AB || req_op_b !== 2'd2) begin
         bad++;
         $display("FAIL to_req_b: got v=%b a=%h op=%0d expected 1 0ab 2",
                  req_valid_b, req_addr_b, req_op_b);
      end
      handshake();
      n = 0;
      while (resp_ready_b && n < 20) begin
         n++;
         tick();
      end
      total++;
      if (n !== 8) begin
         bad++;
         $display("FAIL timeout_cycles: got %0d cycles in wait expected 8", n);
      end
      capture_dtmcs(da, db);
      total++;
      if (db !== 32'h0000_18C1) begin
         bad++;
         $display("FAIL timeout_dtmcs: got %h expected 000018c1", db);
      end
      update_dtmcs(32'h0001_0000);
      shift_dmi({18'd0, 12'h0CD, 32'h66, 2'd2}, 46);
      tick(); tick();
      total++;
      if (req_valid_b !== 1'b1) begin
         bad++;
         $display("FAIL hr_pre_req: got v=%b expected 1", req_valid_b);
      end
      update_dtmcs(32'h0002_0000);
      total++;
      if (req_valid_b !== 1'b0 || resp_ready_b !== 1'b0) begin
         bad++;
         $display("FAIL hardreset_drop: got v=%b rr=%b expected 0 0",
                  req_valid_b, resp_ready_b);
      end
      capture_dtmcs(da, db);
      total++;
      if (db !== 32'h0000_10C1) begin
         bad++;
         $display("FAIL hardreset_dtmcs: got %h expected 000010c1", db);
      end
   endtask

   initial begin
      test_reset();
      test_dtmcs_default();
      test_dr_length();
      test_write();
      test_read();
      test_busy();
      test_failed();
      test_tlr_abort();
      test_timeout_hardreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

endmodule
